// File: rtl/hilo_unit.sv
// hilo_unit
//   Architectural HI/LO register pair sitting beside the iterative
//   multiply/divide unit. Supplies HI/LO to the unit for MADD/MSUB
//   accumulation and commits each result exactly once. Also handles
//   MTHI/MTLO writes and serves MFHI/MFLO with same-cycle forwarding.
//   Generates the pipeline stall and the hold/clear controls for the unit.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   md_busy           unit still computing
//   md_res_valid      unit presents a result (may be held for several cycles)
//   md_hi_res/lo_res  result HI / LO
//   md_hi_q/lo_q      registered HI / LO to the unit (no forwarding)
//   md_hold           keep the unit in its result-holding state
//   md_clear          abort the unit (follows flush_ex)
//   stall_ex          execute stage stalled by a later stage
//   flush_ex          execute stage flushed
//   mthi_we/mtlo_we   writeback-stage MTHI / MTLO
//   mt_data           MT write data
//   mf_req, mf_sel    execute-stage MFHI/MFLO (sel 1 = HI, 0 = LO)
//   mf_data           forwarded MF read data (combinational)
//   stall_req         stall execute and all earlier stages
//   busy_cycles       saturating count of cycles with stall_req=1
module hilo_unit #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          md_busy,
    input  logic          md_res_valid,
    input  logic [N-1:0]  md_hi_res,
    input  logic [N-1:0]  md_lo_res,
    output logic [N-1:0]  md_hi_q,
    output logic [N-1:0]  md_lo_q,
    output logic          md_hold,
    output logic          md_clear,
    input  logic          stall_ex,
    input  logic          flush_ex,
    input  logic          mthi_we,
    input  logic          mtlo_we,
    input  logic [N-1:0]  mt_data,
    input  logic          mf_req,
    input  logic          mf_sel,
    output logic [N-1:0]  mf_data,
    output logic          stall_req,
    output logic [CW-1:0] busy_cycles
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [N-1:0] hi, lo;
    logic         commit;

    // DONE means the held result was already written; a still-asserted
    // md_res_valid there must not write again.
    assign commit = md_res_valid & (state != DONE) & ~flush_ex;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        if (flush_ex) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (md_res_valid)  state_nxt = stall_ex ? DONE : IDLE;
                    else if (md_busy)  state_nxt = BUSY;
                end
                BUSY: begin
                    if (md_res_valid)  state_nxt = stall_ex ? DONE : IDLE;
                end
                DONE: begin
                    if (!stall_ex)     state_nxt = IDLE;
                end
                default:               state_nxt = IDLE;
            endcase
        end
    end

    // Outputs. Reset forces the controls low so nothing leaks out
    // while the register state is being re-initialised.
    always_comb begin
        md_hold   = 1'b0;
        md_clear  = 1'b0;
        stall_req = 1'b0;
        if (!reset) begin
            // Holding keeps the unit from restarting on operands that are
            // still sitting in the stalled execute stage.
            md_hold   = (md_res_valid & stall_ex) | ((state == DONE) & stall_ex);
            md_clear  = flush_ex;
            stall_req = ~flush_ex & (md_busy | (mf_req & (state == BUSY)));
        end
    end

    // HI/LO. A result commit beats a same-cycle MT because the MT belongs
    // to an older instruction and must appear overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= md_hi_res;
            lo <= md_lo_res;
        end else begin
            if (mthi_we) hi <= mt_data;
            if (mtlo_we) lo <= mt_data;
        end
    end

    assign md_hi_q = hi;
    assign md_lo_q = lo;

    // MF forwarding: commit data, then same-cycle MT, then register.
    always_comb begin
        mf_data = mf_sel ? hi : lo;
        if (commit)                 mf_data = mf_sel ? md_hi_res : md_lo_res;
        else if (mf_sel && mthi_we) mf_data = mt_data;
        else if (!mf_sel && mtlo_we) mf_data = mt_data;
    end

    // Saturating stall counter
    always_ff @(posedge clk) begin
        if (reset)
            busy_cycles <= '0;
        else if (stall_req && (busy_cycles != {CW{1'b1}}))
            busy_cycles <= busy_cycles + CW'(1);
    end

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          md_busy, md_res_valid;
    logic [N-1:0]  md_hi_res, md_lo_res;
    logic          stall_ex, flush_ex, mthi_we, mtlo_we, mf_req, mf_sel;
    logic [N-1:0]  mt_data;

    logic [N-1:0]  md_hi_q, md_lo_q, mf_data;
    logic          md_hold, md_clear, stall_req;
    logic [15:0]   busy_cycles;

    logic [N-1:0]  hi4, lo4, mf4;
    logic          hold4, clear4, stall4;
    logic [3:0]    busy4;

    always #5 clk = ~clk;

    hilo_unit #(.N(N), .CW(16)) dut (
        .clk(clk), .reset(reset), .md_busy(md_busy), .md_res_valid(md_res_valid),
        .md_hi_res(md_hi_res), .md_lo_res(md_lo_res), .md_hi_q(md_hi_q), .md_lo_q(md_lo_q),
        .md_hold(md_hold), .md_clear(md_clear), .stall_ex(stall_ex), .flush_ex(flush_ex),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data), .mf_req(mf_req),
        .mf_sel(mf_sel), .mf_data(mf_data), .stall_req(stall_req), .busy_cycles(busy_cycles)
    );

    hilo_unit #(.N(N), .CW(4)) dut4 (
        .clk(clk), .reset(reset), .md_busy(md_busy), .md_res_valid(md_res_valid),
        .md_hi_res(md_hi_res), .md_lo_res(md_lo_res), .md_hi_q(hi4), .md_lo_q(lo4),
        .md_hold(hold4), .md_clear(clear4), .stall_ex(stall_ex), .flush_ex(flush_ex),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data), .mf_req(mf_req),
        .mf_sel(mf_sel), .mf_data(mf4), .stall_req(stall4), .busy_cycles(busy4)
    );

    typedef enum int {S_HI, S_LO, S_MF, S_STALL, S_HOLD, S_CLEAR, S_BUSY, S_BUSY4} sig_e;
    typedef struct {
        int          cyc;
        string       nm;
        sig_e        sig;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(sig_e s);
        case (s)
            S_HI:    return md_hi_q;
            S_LO:    return md_lo_q;
            S_MF:    return mf_data;
            S_STALL: return {31'b0, stall_req};
            S_HOLD:  return {31'b0, md_hold};
            S_CLEAR: return {31'b0, md_clear};
            S_BUSY:  return {16'b0, busy_cycles};
            default: return {28'b0, busy4};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.sig);
            total++;
            if (e.cyc == cyc && a === e.v) passed++;
            else $display("FAIL %s (cycle %0d): got %h, expected %h", e.nm, cyc, a, e.v);
        end
    end

    task automatic expect_v(input string nm, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.nm = nm; e.sig = s; e.v = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        md_busy = 0; md_res_valid = 0; md_hi_res = '0; md_lo_res = '0;
        stall_ex = 0; flush_ex = 0; mthi_we = 0; mtlo_we = 0; mt_data = '0;
        mf_req = 0; mf_sel = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        md_busy = 1;
        step();
        md_res_valid = 1; stall_ex = 1;
        expect_v("rst_stall", S_STALL, 0);
        expect_v("rst_hold",  S_HOLD,  0);
        step();
        idle(); reset = 0;
        expect_v("rst_hi",    S_HI,    0);
        expect_v("rst_lo",    S_LO,    0);
        expect_v("rst_busy",  S_BUSY,  0);
        expect_v("rst_clear", S_CLEAR, 0);
        expect_v("rst_stall_off", S_STALL, 0);

        for (int i = 0; i < 32; i++) begin
            step(); md_busy = 1;
            if (i == 0) expect_v("basic_stall", S_STALL, 1);
        end
        step();
        md_busy = 0; md_res_valid = 1; md_hi_res = 32'h3; md_lo_res = 32'h7;
        expect_v("basic_commit_hold",  S_HOLD,  0);
        expect_v("basic_commit_stall", S_STALL, 0);
        step();
        idle(); mf_req = 1; mf_sel = 0;
        total++;
        if (md_hi_q === 32'h3) passed++;
        else $display("FAIL inline_basic_hi: got %h", md_hi_q);
        total++;
        if (md_lo_q === 32'h7) passed++;
        else $display("FAIL inline_basic_lo: got %h", md_lo_q);
        total++;
        if (busy_cycles === 16'd32) passed++;
        else $display("FAIL inline_basic_busy: got %0d", busy_cycles);
        expect_v("basic_hi",         S_HI,    32'h3);
        expect_v("basic_lo",         S_LO,    32'h7);
        expect_v("basic_busy_count", S_BUSY,  32);
        expect_v("basic_busy4_sat",  S_BUSY4, 15);
        expect_v("basic_idle_stall", S_STALL, 0);
        expect_v("basic_mf_lo",      S_MF,    32'h7);

        step(); idle(); md_busy = 1;
        step(); md_busy = 1;
        step();
        md_busy = 0; md_res_valid = 1; md_hi_res = 32'h11; md_lo_res = 32'h22;
        stall_ex = 1; mf_req = 1; mf_sel = 1;
        expect_v("held_hold1",  S_HOLD, 1);
        expect_v("held_mf_fwd", S_MF,   32'h11);
        step();
        md_hi_res = 32'hFFFF;
        expect_v("held_hold2",   S_HOLD, 1);
        expect_v("held_hi2",     S_HI,   32'h11);
        expect_v("held_mf_done", S_MF,   32'h11);
        step();
        expect_v("held_hold3", S_HOLD, 1);
        expect_v("held_hi3",   S_HI,   32'h11);
        step();
        md_res_valid = 0; stall_ex = 0;
        expect_v("held_release_hold",  S_HOLD,  0);
        expect_v("held_release_stall", S_STALL, 0);
        step();
        idle();
        total++;
        if (md_hi_q === 32'h11) passed++;
        else $display("FAIL inline_held_hi: got %h", md_hi_q);
        expect_v("held_hi", S_HI, 32'h11);
        expect_v("held_lo", S_LO, 32'h22);

        md_busy = 1;
        step();
        md_busy = 0; md_res_valid = 1; md_hi_res = 32'hAAAA; md_lo_res = 32'hBBBB;
        flush_ex = 1; mf_req = 1; mf_sel = 1;
        expect_v("flush_clear", S_CLEAR, 1);
        expect_v("flush_stall", S_STALL, 0);
        expect_v("flush_mf",    S_MF,    32'h11);
        step();
        idle(); mf_req = 1;
        expect_v("flush_clear_off",  S_CLEAR, 0);
        expect_v("flush_hi",         S_HI,    32'h11);
        expect_v("flush_lo",         S_LO,    32'h22);
        expect_v("flush_idle_stall", S_STALL, 0);

        step(); idle(); mthi_we = 1; mt_data = 32'h5;
        step(); idle(); mthi_we = 1; mt_data = 32'h1234; mf_req = 1; mf_sel = 1;
        expect_v("fwd_hi_reg", S_HI, 32'h5);
        expect_v("fwd_mt_hi",  S_MF, 32'h1234);
        step();
        mthi_we = 0; mtlo_we = 1; mt_data = 32'h55;
        expect_v("fwd_unselected_mt", S_MF, 32'h1234);
        step();
        md_res_valid = 1; md_hi_res = 32'h99; md_lo_res = 32'h98;
        mthi_we = 1; mtlo_we = 1; mt_data = 32'h77;
        expect_v("fwd_commit_mf", S_MF, 32'h99);
        expect_v("fwd_lo_pre",    S_LO, 32'h55);
        step();
        idle();
        total++;
        if (md_hi_q === 32'h99) passed++;
        else $display("FAIL inline_fwd_commit_hi: got %h", md_hi_q);
        expect_v("fwd_commit_hi", S_HI, 32'h99);
        expect_v("fwd_commit_lo", S_LO, 32'h98);
        mthi_we = 1; mtlo_we = 1; mt_data = 32'h3C;
        step();
        idle();
        expect_v("mt_both_hi", S_HI, 32'h3C);
        expect_v("mt_both_lo", S_LO, 32'h3C);

        md_busy = 1; mf_req = 1; mf_sel = 0;
        expect_v("mfb_stall0", S_STALL, 1);
        step();
        expect_v("mfb_stall1", S_STALL, 1);
        step();
        md_busy = 0;
        expect_v("mfb_stall_mf_only", S_STALL, 1);
        step();
        md_res_valid = 1; md_hi_res = 32'h101; md_lo_res = 32'h202;
        expect_v("mfb_commit_mf",    S_MF,    32'h202);
        expect_v("mfb_commit_stall", S_STALL, 1);
        step();
        md_res_valid = 0;
        expect_v("mfb_after_stall", S_STALL, 0);
        expect_v("mfb_after_mf",    S_MF,    32'h202);

        step(); idle(); reset = 1;
        step(); reset = 0; md_busy = 1;
        for (int i = 0; i < 19; i++) step();
        step();
        md_busy = 0; md_res_valid = 1; md_hi_res = 32'hC0DE; md_lo_res = 32'hBEEF;
        expect_v("sat_busy4", S_BUSY4, 15);
        expect_v("sat_busy",  S_BUSY,  20);
        step();
        idle(); md_busy = 1;
        expect_v("sat_hi", S_HI, 32'hC0DE);
        step();
        reset = 1; mf_req = 1;
        expect_v("rst2_stall", S_STALL, 0);
        step();
        idle(); reset = 0; mf_req = 1;
        total++;
        if (md_hi_q === '0) passed++;
        else $display("FAIL inline_rst2_hi: got %h", md_hi_q);
        expect_v("rst2_hi",    S_HI,    0);
        expect_v("rst2_lo",    S_LO,    0);
        expect_v("rst2_busy",  S_BUSY,  0);
        expect_v("rst2_busy4", S_BUSY4, 0);
        expect_v("rst2_stall_after", S_STALL, 0);
        expect_v("rst2_hold",  S_HOLD,  0);
        expect_v("rst2_mf",    S_MF,    0);

        step();
        step();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            $display("FAIL %s: never checked, expected %h", e.nm, e.v);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Owns the architectural HI/LO register pair next to the iterative multiply/divide unit.
- Feeds current HI/LO to the multiply/divide unit for MADD/MSUB accumulation.
- Consumes its results and commits each result exactly once.
- Handles MTHI/MTLO writes, serves MFHI/MFLO with forwarding, and generates the pipeline stall and the hold/clear controls for the multiply/divide unit.

Parameters:
- N, 32, data width of HI, LO and all data ports
- CW, 16, width of the saturating busy-cycle performance counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- md_busy  in  1  multiply/divide unit still computing (its waiting_result)
- md_res_valid  in  1  result present (its write_hi_lo)
- md_hi_res  in  N  result HI (quotient/product high)
- md_lo_res  in  N  result LO
- md_hi_q  out  N  current HI to unit (hi_in)
- md_lo_q  out  N  current LO to unit (lo_in)
- md_hold  out  1  keep unit in result-holding state (hold_result)
- md_clear  out  1  abort unit (clear)
- stall_ex  in  1  execute stage stalled by a later stage
- flush_ex  in  1  execute stage flushed
- mthi_we  in  1  writeback-stage MTHI
- mtlo_we  in  1  writeback-stage MTLO
- mt_data  in  N  MT write data
- mf_req  in  1  execute-stage MFHI/MFLO present
- mf_sel  in  1  0 = LO, 1 = HI
- mf_data  out  N  MF read data (combinational, forwarded)
- stall_req  out  1  stall execute and all earlier stages
- busy_cycles  out  CW  count of cycles with stall_req=1, saturating

Behaviour:
- Reset (synchronous, highest priority):
  - HI=0, LO=0, state=IDLE, busy_cycles=0.
  - Outputs md_hold=0, md_clear=0, stall_req=0.
  - Reset mid-operation discards any in-flight result.
- States: IDLE, BUSY, DONE.
  - IDLE: md_busy=1 & md_res_valid=0 -> BUSY. md_res_valid=1 -> commit; DONE if stall_ex, else IDLE.
  - BUSY: md_res_valid=1 -> commit; DONE if stall_ex, else IDLE. Otherwise stay.
  - DONE: result already committed, no further writes. Leave to IDLE when stall_ex=0.
- Commit: HI<=md_hi_res, LO<=md_lo_res in the first cycle md_res_valid=1 outside DONE, only if flush_ex=0. Exactly one commit per operation.
- md_hold:
  - 1 in any cycle with md_res_valid=1 & stall_ex=1, and in DONE while stall_ex=1.
  - Prevents the unit restarting on the still-held operands.
- md_clear = flush_ex, combinational. flush_ex forces state->IDLE and suppresses a same-cycle commit.
- stall_req:
  - = md_busy | (mf_req & state==BUSY).
  - Forced 0 when flush_ex=1.
  - Never depends on mf_data.
- MT writes (when not committing): mthi_we -> HI<=mt_data; mtlo_we -> LO<=mt_data; both may assert together.
  - Commit and MT in the same cycle: commit wins for both registers, because the MT is older.
- mf_data forwarding priority:
  1. Same-cycle commit data (md_res_valid & state!=DONE & !flush_ex).
  2. Same-cycle MT write to the selected register.
  3. Register value.
- md_hi_q/md_lo_q = registered HI/LO, no forwarding. The unit samples them several cycles after issue, by which point MT writes have retired.
- busy_cycles: +1 each cycle stall_req=1. Holds at 2^CW-1. Cleared only by reset.

Test Plan:
- Basic commit: reset; md_busy=1 for 32 cycles, then md_res_valid=1 with hi=0x0000_0003, lo=0x0000_0007, stall_ex=0 -> HI=3, LO=7 next cycle; state IDLE; stall_req high 32 cycles; busy_cycles=32.
- Held result: result arrives with stall_ex=1 for 3 cycles, md_res_valid held high -> single commit on first cycle; md_hold=1 for 3 cycles; a changed md_hi_res=0xFFFF in cycles 2-3 is ignored (HI keeps first value).
- Flush mid-operation: BUSY, then flush_ex=1 the same cycle md_res_valid=1 (hi=0xAAAA) -> md_clear=1, HI unchanged, state IDLE, stall_req=0.
- Forwarding: HI=5; mthi_we=1, mt_data=0x1234 with mf_req=1, mf_sel=1 -> mf_data=0x1234 same cycle. Next, a commit with hi=0x99 in the same cycle as mthi_we=0x77 -> HI=0x99, mf_data=0x99.
- MF during busy: mf_req=1, mf_sel=0 while BUSY -> stall_req=1 until commit cycle; mf_data equals committed LO in that cycle.
- Counter saturation (CW=4): 20 stalled cycles -> busy_cycles=15. Then reset mid-BUSY -> all outputs 0, HI/LO=0.
